decode_dispatch_queue: RTL and testbench
========================================

// Module: decode_dispatch_queue
// PURPOSE
//  RV32I decode/dispatch stage with an instruction queue between IF and issue. Buffers up to
//  IQ_DEPTH fetched instructions, decodes the queue head, allocates a ROB tag, and dispatches
//  one instruction per cycle to the ROB, the ALU reservation station and the load/store buffer.
//  Uses valid/ready handshakes on both sides. Supports flush on misprediction.
// PARAMETERS
//  ROB_WIDTH  4   tag width
//  ROB_SIZE   16  tag count; tags wrap ROB_SIZE-1 -> 0 (power of two not required)
//  IQ_WIDTH   2   queue pointer width; IQ_DEPTH = 2**IQ_WIDTH entries
// PORTS
//  clk_in        in   1          clock
//  rst_in        in   1          reset, asynchronous, active-low
//  rdy_in        in   1          global enable; 0 = all state and outputs hold
//  flush_in      in   1          discard queue and in-flight dispatch; reset tag counter
//  if_valid      in   1          IF presents instruction
//  if_pc         in   32         PC of instruction
//  if_instr      in   32         instruction word
//  if_ready      out  1          queue can accept (comb: count<IQ_DEPTH && !flush_in)
//  rob_ready     in   1          ROB has a free entry
//  rs_ready      in   1          RS has a free entry
//  lsb_ready     in   1          LSB has a free entry
//  disp_valid    out  1          ROB allocate pulse
//  disp_rs_valid out  1          RS write pulse
//  disp_lsb_valid out 1          LSB write pulse
//  disp_op       out  6          op code (ADD=0 .. LUI=36, team op table)
//  disp_rd/rs1/rs2 out 5 each    register fields
//  disp_imm      out  32         decoded immediate
//  disp_pc       out  32         instruction PC
//  disp_tag      out  ROB_WIDTH  allocated ROB tag
// BEHAVIOUR
//  - Reset (rst_in=0): queue empty, ptrs/count=0, tag counter=0. All valids=0.
//    All disp_* data=0. Takes effect immediately, regardless of clock.
//  - Push: the edge with rdy_in && if_valid && if_ready writes {pc,instr} at wr_ptr. wr_ptr wraps.
//  - Head decode is combinational from queue[rd_ptr]. Classes:
//    - ALU/branch/jump/U-type: need RS.
//    - Loads/stores: need RS and LSB.
//    - Illegal: needs nothing.
//  - Fire condition: rdy_in && !flush_in && count>0 && rob_ready && (class-required readies).
//    On the fire edge:
//    - pop the head;
//    - register outputs;
//    - disp_valid=1; disp_rs_valid=1 for non-illegal; disp_lsb_valid=1 for load/store;
//    - disp_tag = tag counter, then the counter increments (wrapping).
//    - Illegal fire: pop only, no valids, no tag consumed (see CONFIGURATION).
//  - Non-fire edge with rdy_in=1: all three valids <= 0. Valids are single-cycle pulses; data
//    holds its last value.
//  - Latency: a push at edge N fires at edge N+1 at the earliest; outputs are valid in the cycle after N+1.
//  - Simultaneous push and pop: count is unchanged; both pointers advance.
//    - Full: if_ready=0; push blocked.
//    - Empty: no fire.
//  - Head blocked (missing ready): the head stays in place, valids drop, and later entries wait (in-order).
//  - flush_in=1 at an edge:
//    - queue emptied, count=0, tag counter=0, valids<=0;
//    - same-cycle push and fire are both suppressed.
//  - Immediates (RV32I exact):
//    - I-type, loads, JALR, SLTI, SLTIU: sext(instr[31:20]).
//    - Shift-immediates: zext(instr[24:20]).
//    - S-type: sext({[31:25],[11:7]}).
//    - B-type: sext({[31],[7],[30:25],[11:8],0}).
//    - JAL: sext({[31],[19:12],[20],[30:21],0}).
//    - LUI/AUIPC: {[31:12],12'b0}.
//    - R-type: 0.
//  - Illegal: unmatched opcode/funct3/funct7 combination, including funct7 not
//    0000000/0100000 on R-type and shifts.
// CONFIGURATION
//  - DECODE_ILLEGAL_TRAP_EN defined:
//    - an illegal head needs rob_ready only;
//    - it fires with disp_valid=1, rs/lsb valids=0, disp_op=6'b111111, and consumes a tag.
//    - The ROB raises the exception at commit.
//  - Undefined: an illegal head is silently dropped (popped, no valid, no tag). This is the default.
// TESTING
//  1. ADDI x1,x0,5 (0x00500093), all ready -> disp_valid=disp_rs_valid=1, lsb=0, op=10, rd=1,
//     rs1=0, imm=5, tag=0; next tag=1.
//  2. LW x2,8(x1) (0x0080A103), lsb_ready=0 for 3 cycles -> no fire and head held;
//     then lsb_ready=1 -> op=23, rs_valid=lsb_valid=1, imm=8.
//  3. JAL x1,-4 (0xFFDFF0EF) -> op=33, imm=0xFFFFFFFC. Also ROB_SIZE=16 with 17 dispatches:
//     17th tag=0 (wrap).
//  4. rob_ready=0, push 4 instrs -> if_ready=0 after 4th and 5th push ignored; rob_ready=1 ->
//     4 fires on consecutive cycles in order, if_ready=1 after the first pop.
//  5. Queue holding 3 entries + flush_in pulse with if_valid=1 -> count=0, no valids, next
//     dispatched tag=0.
//  6. 0x00000000 at head -> TRAP_EN: disp_valid=1, op=63, rs_valid=0; else no valid and the
//     next instruction gets the unconsumed tag.

Source files
------------

// File: rtl/decode_dispatch_queue.sv
// rtl/decode_dispatch_queue.sv - RV32I instruction queue with head decode and in-order dispatch
//
// Buffers up to 2**IQ_WIDTH fetched instructions and decodes the queue head. Each dispatch
// allocates a ROB tag and drives the ROB, the ALU reservation station and the load/store
// buffer. There is one dispatch per cycle, in program order.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   - an illegal head is sent to the ROB only: disp_op = 6'h3F, a tag is consumed,
//               and the ROB raises the exception at commit.
//   undefined - an illegal head is silently popped: no valid is raised and no tag is used.
//
// Ports:
//   clk_in, rst_in (async, active-low)          clock / reset
//   rdy_in                                      global enable; when 0, all state and outputs hold
//   flush_in                                    empties the queue, drops dispatch, clears the tag counter
//   if_valid, if_pc, if_instr / if_ready        fetch-side handshake
//   rob_ready, rs_ready, lsb_ready              downstream free-entry indications
//   disp_valid, disp_rs_valid, disp_lsb_valid   single-cycle write pulses
//   disp_op, disp_rd, disp_rs1, disp_rs2        decoded operation and raw register fields
//   disp_imm, disp_pc, disp_tag                 immediate, instruction PC, allocated ROB tag
//
// Op table:
//   ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
//   ADDI10 SLTI11 SLTIU12 XORI13 ORI14 ANDI15 SLLI16 SRLI17 SRAI18
//   LB19 LBU20 LH21 LHU22 LW23 SB24 SH25 SW26
//   BEQ27 BNE28 BLT29 BGE30 BLTU31 BGEU32 JAL33 JALR34 AUIPC35 LUI36
module decode_dispatch_queue #(
    parameter int ROB_WIDTH = 4,
    parameter int ROB_SIZE  = 16,
    parameter int IQ_WIDTH  = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 if_valid,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_instr,
    output logic                 if_ready,
    input  logic                 rob_ready,
    input  logic                 rs_ready,
    input  logic                 lsb_ready,
    output logic                 disp_valid,
    output logic                 disp_rs_valid,
    output logic                 disp_lsb_valid,
    output logic [5:0]           disp_op,
    output logic [4:0]           disp_rd,
    output logic [4:0]           disp_rs1,
    output logic [4:0]           disp_rs2,
    output logic [31:0]          disp_imm,
    output logic [31:0]          disp_pc,
    output logic [ROB_WIDTH-1:0] disp_tag
);

    localparam int                 IQ_DEPTH = 2 ** IQ_WIDTH;
    localparam logic [IQ_WIDTH:0]  CNT_FULL = (IQ_WIDTH + 1)'(IQ_DEPTH);
    localparam logic [ROB_WIDTH-1:0] TAG_MAX = ROB_WIDTH'(ROB_SIZE - 1);

    logic [31:0]          q_pc    [IQ_DEPTH];
    logic [31:0]          q_instr [IQ_DEPTH];
    logic [IQ_WIDTH-1:0]  wr_ptr;
    logic [IQ_WIDTH-1:0]  rd_ptr;
    logic [IQ_WIDTH:0]    count;
    logic [ROB_WIDTH-1:0] tag_cnt;

    logic [31:0] head_pc;
    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_j, imm_u;
    logic [5:0]  op;
    logic [31:0] imm;
    logic        illegal;
    logic        is_mem;
    logic        head_valid;
    logic        push;
    logic        pop;
    logic        disp_go;

    assign head_pc = q_pc[rd_ptr];
    assign ins     = q_instr[rd_ptr];
    assign opcode  = ins[6:0];
    assign funct3  = ins[14:12];
    assign funct7  = ins[31:25];

    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_sh = {27'd0, ins[24:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_u  = {ins[31:12], 12'd0};

    always_comb begin
        op      = 6'd0;
        imm     = 32'd0;
        illegal = 1'b0;
        is_mem  = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0:    op = 6'd0;
                        3'd1:    op = 6'd2;
                        3'd2:    op = 6'd3;
                        3'd3:    op = 6'd4;
                        3'd4:    op = 6'd5;
                        3'd5:    op = 6'd6;
                        3'd6:    op = 6'd8;
                        default: op = 6'd9;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    op = 6'd1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    op = 6'd7;
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0010011: begin
                imm = imm_i;
                case (funct3)
                    3'd0: op = 6'd10;
                    3'd2: op = 6'd11;
                    3'd3: op = 6'd12;
                    3'd4: op = 6'd13;
                    3'd6: op = 6'd14;
                    3'd7: op = 6'd15;
                    3'd1: begin
                        imm = imm_sh;
                        if (funct7 == 7'b0000000) op = 6'd16;
                        else                      illegal = 1'b1;
                    end
                    default: begin
                        imm = imm_sh;
                        if (funct7 == 7'b0000000)      op = 6'd17;
                        else if (funct7 == 7'b0100000) op = 6'd18;
                        else                           illegal = 1'b1;
                    end
                endcase
            end
            7'b0000011: begin
                is_mem = 1'b1;
                imm    = imm_i;
                case (funct3)
                    3'd0:    op = 6'd19;
                    3'd4:    op = 6'd20;
                    3'd1:    op = 6'd21;
                    3'd5:    op = 6'd22;
                    3'd2:    op = 6'd23;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                is_mem = 1'b1;
                imm    = imm_s;
                case (funct3)
                    3'd0:    op = 6'd24;
                    3'd1:    op = 6'd25;
                    3'd2:    op = 6'd26;
                    default: illegal = 1'b1;
                endcase
            end
            7'b1100011: begin
                imm = imm_b;
                case (funct3)
                    3'd0:    op = 6'd27;
                    3'd1:    op = 6'd28;
                    3'd4:    op = 6'd29;
                    3'd5:    op = 6'd30;
                    3'd6:    op = 6'd31;
                    3'd7:    op = 6'd32;
                    default: illegal = 1'b1;
                endcase
            end
            7'b1101111: begin
                op  = 6'd33;
                imm = imm_j;
            end
            7'b1100111: begin
                imm = imm_i;
                if (funct3 == 3'd0) op = 6'd34;
                else                illegal = 1'b1;
            end
            7'b0010111: begin
                op  = 6'd35;
                imm = imm_u;
            end
            7'b0110111: begin
                op  = 6'd36;
                imm = imm_u;
            end
            default: illegal = 1'b1;
        endcase
        // An illegal word carries no meaningful immediate and never reaches the LSB.
        if (illegal) begin
            imm    = 32'd0;
            is_mem = 1'b0;
        end
    end

    assign head_valid = (count != '0);
    assign if_ready   = (count < CNT_FULL) && !flush_in;
    assign push       = rdy_in && if_valid && if_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Illegal heads still occupy a ROB entry so the exception surfaces at commit.
    assign disp_go = rdy_in && !flush_in && head_valid && rob_ready &&
                     (illegal || (rs_ready && (!is_mem || lsb_ready)));
    assign pop     = disp_go;
`else
    // Illegal heads are dropped without waiting on any downstream resource.
    assign disp_go = rdy_in && !flush_in && head_valid && !illegal && rob_ready &&
                     rs_ready && (!is_mem || lsb_ready);
    assign pop     = disp_go || (rdy_in && !flush_in && head_valid && illegal);
`endif

    // Queue payload carries no reset; count guards every read of it.
    always_ff @(posedge clk_in) begin
        if (push) begin
            q_pc[wr_ptr]    <= if_pc;
            q_instr[wr_ptr] <= if_instr;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tag_cnt        <= '0;
            disp_valid     <= 1'b0;
            disp_rs_valid  <= 1'b0;
            disp_lsb_valid <= 1'b0;
            disp_op        <= 6'd0;
            disp_rd        <= 5'd0;
            disp_rs1       <= 5'd0;
            disp_rs2       <= 5'd0;
            disp_imm       <= 32'd0;
            disp_pc        <= 32'd0;
            disp_tag       <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                count          <= '0;
                tag_cnt        <= '0;
                disp_valid     <= 1'b0;
                disp_rs_valid  <= 1'b0;
                disp_lsb_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;

                if (disp_go) begin
                    disp_valid     <= 1'b1;
                    disp_rs_valid  <= !illegal;
                    disp_lsb_valid <= is_mem;
                    disp_op        <= illegal ? 6'h3F : op;
                    disp_rd        <= ins[11:7];
                    disp_rs1       <= ins[19:15];
                    disp_rs2       <= ins[24:20];
                    disp_imm       <= imm;
                    disp_pc        <= head_pc;
                    disp_tag       <= tag_cnt;
                    tag_cnt        <= (tag_cnt == TAG_MAX) ? '0 : tag_cnt + 1'b1;
                end else begin
                    disp_valid     <= 1'b0;
                    disp_rs_valid  <= 1'b0;
                    disp_lsb_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb/tb_decode_dispatch_queue.sv - scoreboard testbench for decode_dispatch_queue
module tb_decode_dispatch_queue;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        rob_ready;
    logic        rs_ready;
    logic        lsb_ready;
    logic        disp_valid;
    logic        disp_rs_valid;
    logic        disp_lsb_valid;
    logic [5:0]  disp_op;
    logic [4:0]  disp_rd;
    logic [4:0]  disp_rs1;
    logic [4:0]  disp_rs2;
    logic [31:0] disp_imm;
    logic [31:0] disp_pc;
    logic [3:0]  disp_tag;

    always #5 clk_in = ~clk_in;

    decode_dispatch_queue #(.ROB_WIDTH(4), .ROB_SIZE(16), .IQ_WIDTH(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .rob_ready      (rob_ready),
        .rs_ready       (rs_ready),
        .lsb_ready      (lsb_ready),
        .disp_valid     (disp_valid),
        .disp_rs_valid  (disp_rs_valid),
        .disp_lsb_valid (disp_lsb_valid),
        .disp_op        (disp_op),
        .disp_rd        (disp_rd),
        .disp_rs1       (disp_rs1),
        .disp_rs2       (disp_rs2),
        .disp_imm       (disp_imm),
        .disp_pc        (disp_pc),
        .disp_tag       (disp_tag)
    );

    // Stimulus table: ADDI, LW, JAL, SUB, SW, BEQ, SRAI, LUI, all-zero word, MUL (illegal in RV32I).
    // cls: 0 = needs RS, 1 = needs RS+LSB, 2 = illegal.
    logic [31:0] t_instr [10] = '{32'h00500093, 32'h0080A103, 32'hFFDFF0EF, 32'h402081B3,
                                  32'h0020A623, 32'hFE208CE3, 32'h40335293, 32'h123453B7,
                                  32'h00000000, 32'h023100B3};
    logic [5:0]  t_op    [10] = '{6'd10, 6'd23, 6'd33, 6'd1, 6'd26, 6'd27, 6'd18, 6'd36, 6'd63, 6'd63};
    logic [4:0]  t_rd    [10] = '{5'd1, 5'd2, 5'd1, 5'd3, 5'd12, 5'd25, 5'd5, 5'd7, 5'd0, 5'd1};
    logic [4:0]  t_rs1   [10] = '{5'd0, 5'd1, 5'd31, 5'd1, 5'd1, 5'd1, 5'd6, 5'd8, 5'd0, 5'd2};
    logic [31:0] t_imm   [10] = '{32'd5, 32'd8, 32'hFFFFFFFC, 32'd0, 32'd12, 32'hFFFFFFF8,
                                  32'd3, 32'h12345000, 32'd0, 32'd0};
    logic [1:0]  t_cls   [10] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
        logic        rs_v;
        logic        lsb_v;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] model_tag = 4'd0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one fetch beat starting at a negedge; the expected dispatch is queued if accepted.
    task automatic push_instr(input int idx, input logic [31:0] pc, output bit accepted);
        exp_t e;
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = t_instr[idx];
        #1;
        accepted = if_ready;
        if (accepted && (t_cls[idx] != 2'd2 || TRAP)) begin
            e.op    = t_op[idx];
            e.rd    = t_rd[idx];
            e.rs1   = t_rs1[idx];
            e.imm   = t_imm[idx];
            e.pc    = pc;
            e.tag   = model_tag;
            e.rs_v  = (t_cls[idx] != 2'd2);
            e.lsb_v = (t_cls[idx] == 2'd1);
            sb.push_back(e);
            model_tag = (model_tag == 4'd15) ? 4'd0 : model_tag + 4'd1;
        end
        @(negedge clk_in);
        if_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        check_eq(tag, sb.size(), 0);
        repeat (2) @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (disp_valid) begin
                check_eq("disp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check_eq("op",    disp_op,        mon_e.op);
                    check_eq("rd",    disp_rd,        mon_e.rd);
                    check_eq("rs1",   disp_rs1,       mon_e.rs1);
                    check_eq("imm",   disp_imm,       mon_e.imm);
                    check_eq("pc",    disp_pc,        mon_e.pc);
                    check_eq("tag",   disp_tag,       mon_e.tag);
                    check_eq("rs_v",  disp_rs_valid,  mon_e.rs_v);
                    check_eq("lsb_v", disp_lsb_valid, mon_e.lsb_v);
                end
            end else begin
                check_eq("stray_valid", {disp_rs_valid, disp_lsb_valid}, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        if_valid = 1'b0; if_pc = 32'd0; if_instr = 32'd0;
        rob_ready = 1'b1; rs_ready = 1'b1; lsb_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        check_eq("rst_valids", {disp_valid, disp_rs_valid, disp_lsb_valid}, 0);
        check_eq("rst_tag", disp_tag, 0);
        check_eq("rst_op", disp_op, 0);
        check_eq("rst_imm", disp_imm, 0);
        check_eq("rst_pc", disp_pc, 0);
        check_eq("rst_if_ready", if_ready, 1);
        rst_in = 1'b1;
        @(negedge clk_in);

        // ADDI with everything ready: one-edge latency after the push
        push_instr(0, 32'h1000, acc);
        check_eq("lat_push_edge", disp_valid, 0);
        @(negedge clk_in);
        check_eq("lat_fire_edge", disp_valid, 1);
        wait_drain("t1_drain");

        // LW held while the LSB is full
        lsb_ready = 1'b0;
        push_instr(1, 32'h1004, acc);
        repeat (3) begin
            check_eq("lsb_hold", disp_valid, 0);
            @(negedge clk_in);
        end
        lsb_ready = 1'b1;
        wait_drain("t2_drain");

        // JAL, then enough traffic to wrap the 16-entry tag space
        push_instr(2, 32'h1008, acc);
        wait_drain("t3_jal_drain");
        for (int i = 0; i < 16; i++) push_instr(i % 8, 32'h2000 + 4 * i, acc);
        wait_drain("t3_wrap_drain");

        // rdy_in low freezes a head that would otherwise fire
        push_instr(3, 32'h3000, acc);
        rdy_in = 1'b0;
        repeat (2) begin
            @(negedge clk_in);
            check_eq("rdy_hold", disp_valid, 0);
        end
        rdy_in = 1'b1;
        wait_drain("rdy_drain");

        // Fill the queue behind a stalled ROB, then release it
        rob_ready = 1'b0;
        push_instr(0, 32'h4000, acc); check_eq("t4_acc0", acc, 1);
        push_instr(1, 32'h4004, acc); check_eq("t4_acc1", acc, 1);
        push_instr(4, 32'h4008, acc); check_eq("t4_acc2", acc, 1);
        push_instr(6, 32'h400C, acc); check_eq("t4_acc3", acc, 1);
        check_eq("t4_full", if_ready, 0);
        push_instr(7, 32'h4010, acc); check_eq("t4_blocked", acc, 0);
        rob_ready = 1'b1;
        @(negedge clk_in);
        check_eq("t4_fire0", disp_valid, 1);
        check_eq("t4_if_ready", if_ready, 1);
        repeat (3) begin
            @(negedge clk_in);
            check_eq("t4_consec", disp_valid, 1);
        end
        wait_drain("t4_drain");

        // Flush with three queued entries and a concurrent fetch
        rob_ready = 1'b0;
        push_instr(0, 32'h5000, acc);
        push_instr(3, 32'h5004, acc);
        push_instr(6, 32'h5008, acc);
        flush_in = 1'b1; if_valid = 1'b1; if_instr = t_instr[0]; if_pc = 32'h500C;
        #1;
        check_eq("flush_if_ready", if_ready, 0);
        @(negedge clk_in);
        flush_in = 1'b0; if_valid = 1'b0;
        sb.delete();
        model_tag = 4'd0;
        rob_ready = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check_eq("flush_no_valid", disp_valid, 0);
        end
        push_instr(5, 32'h6000, acc);
        wait_drain("t5_drain");

        // Illegal words interleaved with legal ones
        push_instr(8, 32'h7000, acc);
        push_instr(0, 32'h7004, acc);
        push_instr(9, 32'h7008, acc);
        push_instr(3, 32'h700C, acc);
        wait_drain("t6_drain");
        repeat (4) @(negedge clk_in);
        check_eq("sb_final", sb.size(), 0);

        // Asynchronous reset while a dispatch is visible
        push_instr(7, 32'h8000, acc);
        for (int n = 0; n < 10 && !disp_valid; n++) @(negedge clk_in);
        check_eq("async_pre_valid", disp_valid, 1);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("async_valid", disp_valid, 0);
        check_eq("async_pc", disp_pc, 0);
        check_eq("async_tag", disp_tag, 0);
        sb.delete();
        model_tag = 4'd0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
